// File: rtl/fifo_reader.sv
// Burst reader: pulls len_i words from an upstream FIFO with one-cycle read latency
// and streams them through a 2-entry skid buffer onto a valid/ready output.
module fifo_reader #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  // Output handshake: a word moves when m_valid_o && m_ready_i on a rising edge;
  // m_valid_o never depends on m_ready_i and m_data_o is held while stalled.

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           state_q;
  logic [CNT_WIDTH-1:0] issue_cnt_q;
  logic                 inflight_q;
  logic [1:0]           occ_q;
  logic [WIDTH-1:0]     skid0_q;
  logic [WIDTH-1:0]     skid1_q;
  logic                 done_q;

  logic                 pop;
  logic                 push;
  logic [1:0]           occ_eff;
  logic                 rd_en;

  assign pop  = (occ_q != 2'd0) && m_ready_i;
  assign push = inflight_q;

  // Entries committed after this edge: the head leaving now frees its slot,
  // which keeps one read per cycle while the consumer is accepting.
  assign occ_eff = occ_q - {1'b0, pop} + {1'b0, inflight_q};

  assign rd_en = (state_q == BURST) && (issue_cnt_q != '0) && !fifo_empty_i &&
                 (occ_eff < 2'd2);

  assign fifo_rd_en_o = rd_en;
  assign m_data_o     = skid0_q;
  assign m_valid_o    = (occ_q != 2'd0);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign state_o      = state_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              issue_cnt_q <= len_i;
              state_q     <= BURST;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        BURST: begin
          if (rd_en) begin
            issue_cnt_q <= issue_cnt_q - 1'b1;
            if (issue_cnt_q == CNT_WIDTH'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Complete on the edge where the last word leaves, so done follows it directly.
          if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      skid0_q    <= '0;
      skid1_q    <= '0;
    end else begin
      inflight_q <= rd_en;
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) skid0_q <= fifo_rdata_i;
          else               skid1_q <= fifo_rdata_i;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          skid0_q <= skid1_q;
          occ_q   <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            skid0_q <= fifo_rdata_i;
          end else begin
            skid0_q <= skid1_q;
            skid1_q <= fifo_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits.
REQ-002 Parameter DEPTH, default 16, depth of the upstream FIFO; sets the maximum burst length.
REQ-003 Parameter CNT_WIDTH, default $clog2(DEPTH)+1, width of the burst length and counters.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-006 start_i  input  1  burst request, sampled only in IDLE.
REQ-007 len_i  input  CNT_WIDTH  number of words to read, sampled with start_i.
REQ-008 fifo_rdata_i  input  WIDTH  FIFO read data, valid the cycle after fifo_rd_en_o.
REQ-009 fifo_empty_i  input  1  FIFO empty flag.
REQ-010 fifo_rd_en_o  output  1  FIFO read strobe.
REQ-011 m_data_o  output  WIDTH  downstream data.
REQ-012 m_valid_o  output  1  downstream data valid.
REQ-013 m_ready_i  input  1  downstream accept.
REQ-014 busy_o  output  1  high while the state is not IDLE.
REQ-015 done_o  output  1  one-cycle pulse when a burst completes.

Function
REQ-016 The FSM SHALL have three states: IDLE, BURST and DRAIN.
REQ-017 IDLE: start_i=1 with len_i>0 SHALL load issue_cnt=len_i and move to BURST on the next edge.
REQ-018 IDLE: start_i=1 with len_i=0 SHALL pulse done_o on the next cycle, stay in IDLE and issue no reads.
REQ-019 start_i SHALL be ignored while busy_o=1.
REQ-020 fifo_rd_en_o SHALL be combinational: high only when state=BURST, issue_cnt>0, fifo_empty_i=0, and (skid occupancy + in-flight read) < 2.
REQ-021 Each cycle with fifo_rd_en_o=1 SHALL decrement issue_cnt by 1 and set the in-flight flag.
REQ-022 The in-flight flag SHALL cause fifo_rdata_i to be written into the 2-entry skid buffer on the following edge.
REQ-023 The skid buffer SHALL be FIFO-ordered; the head SHALL drive m_data_o, and m_valid_o SHALL equal (occupancy > 0).
REQ-024 m_data_o and m_valid_o SHALL come from registers; no combinational path from m_ready_i to m_valid_o.
REQ-025 A transfer occurs when m_valid_o=1 and m_ready_i=1; it SHALL pop the head.
REQ-026 A push and a pop in the same cycle SHALL leave occupancy unchanged and preserve order.
REQ-027 m_data_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-028 Throughput SHALL be 1 word/cycle when fifo_empty_i=0 and m_ready_i=1 are held continuously.
REQ-029 BURST SHALL move to DRAIN on the edge where issue_cnt reaches 0.
REQ-030 DRAIN SHALL wait until the in-flight flag is 0 and occupancy is 0, then pulse done_o for 1 cycle and return to IDLE.
REQ-031 fifo_empty_i=1 SHALL stall issue without error; the burst resumes when the flag clears.
REQ-032 len_i > DEPTH SHALL be accepted; reads are paced only by fifo_empty_i.
REQ-033 m_ready_i=0 with 2 entries held SHALL force fifo_rd_en_o=0.
REQ-034 Data SHALL never be dropped or duplicated.
REQ-035 Implementation SHALL be 120-400 lines of RTL.

Reset
REQ-036 rst_i=0 SHALL immediately force: state=IDLE, issue_cnt=0, in-flight=0, occupancy=0, m_data_o=0, m_valid_o=0, done_o=0, busy_o=0.
REQ-037 While rst_i=0, fifo_rd_en_o SHALL be 0.
REQ-038 Reset during BURST or DRAIN SHALL abort the burst, SHALL NOT pulse done_o, and SHALL discard any in-flight word.
REQ-039 Deassertion of rst_i SHALL be synchronized by the integrator; the first active edge after deassertion SHALL behave as IDLE.

Verification
REQ-040 Streaming: len_i=4, FIFO holding 0xA,0xB,0xC,0xD, m_ready_i=1 -> fifo_rd_en_o high 4 consecutive cycles, m_data_o A,B,C,D on consecutive cycles, first valid 2 cycles after start_i, done_o 1 cycle after last transfer.
REQ-041 Backpressure: len_i=5, m_ready_i=0 for 6 cycles then 1 -> exactly 2 reads issued, then fifo_rd_en_o=0, m_data_o held at word 0; all 5 words delivered in order after release.
REQ-042 Empty stall: len_i=3, fifo_empty_i=1 for cycles 2-5 -> no reads during the stall, busy_o=1 throughout, 3 words delivered, single done_o pulse.
REQ-043 Zero length plus ignored start: len_i=0 -> done_o after 1 cycle, no fifo_rd_en_o; start_i mid-burst -> no effect on issue_cnt.
REQ-044 Reset mid-burst: rst_i=0 after 2 of 8 words -> all outputs 0 immediately, no done_o; a new burst with len_i=2 then completes normally.
REQ-045 Simultaneous push/pop: occupancy=1, m_ready_i=1, read in flight -> occupancy stays 1, order preserved, no gap in m_valid_o.
